// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave responder: mode encodings, FSM states,
// frame width / idle byte defaults and RX FIFO depth.
package spi_pkg;

  localparam int unsigned SPI_DATA_W        = 8;
  localparam logic [7:0]  SPI_TX_IDLE       = 8'hFF;
  localparam int unsigned SPI_RX_FIFO_DEPTH = 4;

  // SCK idle level and sampling phase encodings
  localparam logic SPI_CPOL_LOW   = 1'b0;
  localparam logic SPI_CPOL_HIGH  = 1'b1;
  localparam logic SPI_CPHA_LEAD  = 1'b0;
  localparam logic SPI_CPHA_TRAIL = 1'b1;

  // Frame FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin followed by a registered
// rise/fall detector. Edge pulses appear 3 clk cycles after the pin toggles.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronize, keep one delayed copy, and register the edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s3   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave responder: oversamples SCK/MOSI/SS_N, shifts MSB-first frames,
// returns a preloaded TX byte on MISO, and hands RX bytes to local logic.
// Optional: define SPI_SLAVE_RX_FIFO_EN for a 4-entry RX FIFO in front of
// the rx handshake (default: single RX register).
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int unsigned        DATA_W  = SPI_DATA_W,
  parameter logic               CPOL    = SPI_CPOL_LOW,
  parameter logic               CPHA    = SPI_CPHA_LEAD,
  parameter logic [DATA_W-1:0]  TX_IDLE = DATA_W'(SPI_TX_IDLE)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sck_i,
  input  logic              mosi_i,
  input  logic              ss_n_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic              sck_rise, sck_fall, ss_rise, ss_fall;
  logic              mosi_m, mosi_s;
  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, hold_data, load_byte_c;
  logic              sample_c, shift_c;
  logic              load_c, sample_en_c, shift_en_c, deliver_c, abort_c;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
    .clk (wb_clk_i), .rst (wb_rst_i), .d (sck_i),
    .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk (wb_clk_i), .rst (wb_rst_i), .d (ss_n_i),
    .rise(ss_rise), .fall(ss_fall)
  );

  // MOSI only needs synchronizing; it is consumed on SCK sample edges
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      mosi_m <= mosi_i;
      mosi_s <= mosi_m;
    end
  end

  // Map SCK edges to sample/shift events for the configured mode
  always_comb begin
    sample_c    = 1'b0;
    shift_c     = 1'b0;
    load_byte_c = tx_ready_o ? TX_IDLE : hold_data;
    if (CPHA == SPI_CPHA_LEAD) begin
      sample_c = (CPOL == SPI_CPOL_HIGH) ? sck_fall : sck_rise;
      shift_c  = (CPOL == SPI_CPOL_HIGH) ? sck_rise : sck_fall;
    end else begin
      sample_c = (CPOL == SPI_CPOL_HIGH) ? sck_rise : sck_fall;
      shift_c  = (CPOL == SPI_CPOL_HIGH) ? sck_fall : sck_rise;
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_d;
  end

  // FSM next state and per-cycle datapath strobes
  always_comb begin
    state_d     = state;
    load_c      = 1'b0;
    sample_en_c = 1'b0;
    shift_en_c  = 1'b0;
    deliver_c   = 1'b0;
    abort_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          load_c  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          abort_c = 1'b1;
          state_d = ST_IDLE;
        end else if (sample_c) begin
          sample_en_c = 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
        end else if (shift_c && (CPHA == SPI_CPHA_TRAIL || bit_cnt != '0)) begin
          // CPHA=0: the MSB went out at load, and the trailing edge of the
          // previous frame's last bit must not disturb the new frame
          shift_en_c = 1'b1;
        end
      end
      ST_DONE: begin
        deliver_c = 1'b1;
        if (ss_rise) begin
          abort_c = 1'b1;
          state_d = ST_IDLE;
        end else begin
          load_c  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift registers, bit counter, MISO drive and busy flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      miso_o    <= TX_IDLE[DATA_W-1];
      miso_oe_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      if (ss_fall)      busy_o <= 1'b1;
      else if (ss_rise) busy_o <= 1'b0;

      if (abort_c) begin
        bit_cnt   <= '0;
        miso_oe_o <= 1'b0;
        miso_o    <= TX_IDLE[DATA_W-1];
      end else if (load_c) begin
        bit_cnt   <= '0;
        miso_oe_o <= 1'b1;
        if (CPHA == SPI_CPHA_LEAD) begin
          miso_o   <= load_byte_c[DATA_W-1];
          tx_shift <= {load_byte_c[DATA_W-2:0], 1'b0};
        end else begin
          tx_shift <= load_byte_c;
        end
      end else if (sample_en_c) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end else if (shift_en_c) begin
        miso_o   <= tx_shift[DATA_W-1];
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  // TX holding register; a capture coinciding with a load serves the next frame
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hold_data     <= '0;
      tx_ready_o    <= 1'b1;
      tx_underrun_o <= 1'b0;
    end else begin
      if (tx_valid_i && tx_ready_o) begin
        hold_data  <= tx_data_i;
        tx_ready_o <= 1'b0;
      end else if (load_c && !tx_ready_o) begin
        tx_ready_o <= 1'b1;
      end
      if (load_c && tx_ready_o) tx_underrun_o <= 1'b1;
    end
  end

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int unsigned PTR_W  = $clog2(SPI_RX_FIFO_DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;

  logic [DATA_W-1:0] fifo_mem [SPI_RX_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_d;
  logic [CNT_FW-1:0] fifo_cnt, fifo_cnt_d;
  logic              push_c, pop_c;
  logic [DATA_W-1:0] head_d;

  // Next FIFO occupancy and the byte that will sit at the head
  always_comb begin
    pop_c      = rx_valid_o && rx_ready_i;
    push_c     = deliver_c && (fifo_cnt != CNT_FW'(SPI_RX_FIFO_DEPTH));
    rd_ptr_d   = rd_ptr + PTR_W'(pop_c);
    fifo_cnt_d = fifo_cnt + CNT_FW'(push_c) - CNT_FW'(pop_c);
    head_d     = (push_c && wr_ptr == rd_ptr_d) ? rx_shift : fifo_mem[rd_ptr_d];
  end

  // FIFO storage
  always_ff @(posedge wb_clk_i) begin
    if (push_c) fifo_mem[wr_ptr] <= rx_shift;
  end

  // FIFO pointers, registered head/valid and overrun on a full FIFO
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_d;
      fifo_cnt   <= fifo_cnt_d;
      rx_valid_o <= (fifo_cnt_d != '0);
      if (fifo_cnt_d != '0) rx_data_o <= head_d;
      if (deliver_c && !push_c) rx_overrun_o <= 1'b1;
    end
  end
`else
  // Single RX register: a new byte always wins, overrun if unread
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else if (deliver_c) begin
      rx_data_o  <= rx_shift;
      rx_valid_o <= 1'b1;
      if (rx_valid_o && !rx_ready_i) rx_overrun_o <= 1'b1;
    end else if (rx_valid_o && rx_ready_i) begin
      rx_valid_o <= 1'b0;
    end
  end
`endif

endmodule
